fetch_unit: RTL

Instruction-fetch stage sitting directly upstream of the fetch/decode pipeline register. Owns the PC, issues single-outstanding requests to instruction memory, and buffers the returned word. Presents instr_o/next_pc_o/valid_o for the pipeline register to latch. Handles downstream stall and branch/jump redirect, discarding stale memory responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_perf_ctr.sv | 28 ++
 rtl/fetch_unit_chk.sv | 20 ++
 rtl/fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch stage and
// the fetch/decode pipeline registers.
//   fetch_state_e : fetch sequencer state (ISSUE -> WAIT -> HAVE)
//   FETCH_IWIDTH  : default instruction width
//   FETCH_PWIDTH  : default PC / word-address width
//   FETCH_NOP     : instruction presented when nothing is live (all zeros)
package fetch_pkg;

  localparam int unsigned FETCH_IWIDTH = 32'd24;
  localparam int unsigned FETCH_PWIDTH = 32'd16;

  localparam logic [FETCH_IWIDTH-1:0] FETCH_NOP = {FETCH_IWIDTH{1'b0}};

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HAVE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: 32-bit event counter with enable that sticks at all-ones.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset, clears the count
//   en_i    : count one event this cycle
//   count_o : registered event count
module fetch_perf_ctr (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_r;

  // Saturating count register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_r <= 32'd0;
    end else if (en_i && (count_r != 32'hFFFF_FFFF)) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/fetch_unit_chk.sv
// fetch_unit_chk: simulation-only protocol checker for fetch_unit.
// A memory response is only legal while the fetch unit is waiting for one.
//   clk_i, rst_ni  : clock and synchronous active-low reset
//   imem_rvalid_i  : memory response valid
//   state_i        : current fetch state
module fetch_unit_chk
  import fetch_pkg::*;
(
  input logic         clk_i,
  input logic         rst_ni,
  input logic         imem_rvalid_i,
  input fetch_state_e state_i
);

  // A response arriving in ISSUE or HAVE is ignored by the datapath but flagged here.
  rvalid_only_in_wait_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (state_i == WAIT)
  );

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the fetch/decode pipeline register.
// Owns the PC, keeps at most one request outstanding to instruction memory,
// buffers the returned word and presents it until the pipeline accepts it.
// Branch/jump redirects reload the PC and any in-flight response is discarded.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_ni         : synchronous active-low reset
//   stall_i        : downstream cannot accept, hold the current instruction
//   redirect_i     : branch/jump taken, load redirect_pc_i (beats stall_i)
//   redirect_pc_i  : redirect target
//   imem_req_o     : one-cycle request pulse to instruction memory
//   imem_addr_o    : request address (meaningful only with imem_req_o)
//   imem_rvalid_i  : memory response valid
//   imem_rdata_i   : memory response data
//   instr_o        : fetched instruction, NOP when valid_o=0
//   next_pc_o      : PC of instr_o plus PC_STEP, 0 when valid_o=0
//   valid_o        : instr_o/next_pc_o hold a live instruction
//   perf_fetched_o : (FETCH_PERF_EN only) instructions handed downstream
//   perf_stall_o   : (FETCH_PERF_EN only) cycles a live instruction was stalled
//
// Build option: define FETCH_PERF_EN to add the two performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IWIDTH   = FETCH_IWIDTH,
  parameter int unsigned PWIDTH   = FETCH_PWIDTH,
  parameter int unsigned RESET_PC = 32'd0,
  parameter int unsigned PC_STEP  = 32'd1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [PWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [PWIDTH-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [IWIDTH-1:0] imem_rdata_i,
  output logic [IWIDTH-1:0] instr_o,
  output logic [PWIDTH-1:0] next_pc_o,
  output logic              valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam logic [PWIDTH-1:0] RESET_PC_W = PWIDTH'(RESET_PC);
  localparam logic [PWIDTH-1:0] PC_STEP_W  = PWIDTH'(PC_STEP);
  localparam logic [IWIDTH-1:0] NOP_W      = IWIDTH'(FETCH_NOP);
  localparam logic [PWIDTH-1:0] PC_ZERO    = {PWIDTH{1'b0}};

  fetch_state_e      state_r, state_s;
  logic [PWIDTH-1:0] pc_r, pc_s;
  logic              drop_r, drop_s;
  logic [IWIDTH-1:0] buf_r, buf_s;

  logic              req_r;
  logic [PWIDTH-1:0] addr_r;
  logic              valid_r;
  logic [IWIDTH-1:0] instr_r;
  logic [PWIDTH-1:0] npc_r;

  // Next-state decode for the fetch sequencer, PC, drop flag and buffer.
  always_comb begin
    state_s = state_r;
    drop_s  = drop_r;
    buf_s   = buf_r;
    // A redirect reloads the PC in every state; the PC is otherwise only
    // advanced when a live instruction leaves HAVE.
    if (redirect_i) begin
      pc_s = redirect_pc_i;
    end else begin
      pc_s = pc_r;
    end

    case (state_r)
      ISSUE: begin
        // The request at the old PC is already out; remember to discard it.
        state_s = WAIT;
        if (redirect_i) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_r;
        end
      end

      WAIT: begin
        if (imem_rvalid_i) begin
          if (drop_r || redirect_i) begin
            // Stale response: throw it away and refetch from the new PC.
            drop_s  = 1'b0;
            state_s = ISSUE;
          end else begin
            buf_s   = imem_rdata_i;
            state_s = HAVE;
          end
        end else if (redirect_i) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_r;
        end
      end

      HAVE: begin
        if (redirect_i) begin
          // The displayed instruction is squashed and does not advance the PC.
          buf_s   = NOP_W;
          state_s = ISSUE;
        end else if (!stall_i) begin
          pc_s    = pc_r + PC_STEP_W;
          state_s = ISSUE;
        end else begin
          state_s = HAVE;
        end
      end

      default: begin
        state_s = ISSUE;
        drop_s  = 1'b0;
        buf_s   = NOP_W;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ISSUE;
      pc_r    <= RESET_PC_W;
      drop_r  <= 1'b0;
      buf_r   <= NOP_W;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      drop_r  <= drop_s;
      buf_r   <= buf_s;
    end
  end

  // Output registers, loaded from the next-state values so they always match
  // a decode of the state register without a combinational output path.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_r   <= 1'b1;
      addr_r  <= RESET_PC_W;
      valid_r <= 1'b0;
      instr_r <= NOP_W;
      npc_r   <= PC_ZERO;
    end else begin
      req_r  <= (state_s == ISSUE);
      addr_r <= pc_s;
      if (state_s == HAVE) begin
        valid_r <= 1'b1;
        instr_r <= buf_s;
        npc_r   <= pc_s + PC_STEP_W;
      end else begin
        valid_r <= 1'b0;
        instr_r <= NOP_W;
        npc_r   <= PC_ZERO;
      end
    end
  end

  // The request register comes out of reset already set for the first ISSUE,
  // so it is masked while reset is still held.
  assign imem_req_o  = req_r & rst_ni;
  assign imem_addr_o = addr_r;
  assign valid_o     = valid_r;
  assign instr_o     = instr_r;
  assign next_pc_o   = npc_r;

`ifdef FETCH_PERF_EN
  logic fetched_en_s;
  logic stall_en_s;

  assign fetched_en_s = (state_r == HAVE) && !stall_i && !redirect_i;
  assign stall_en_s   = (state_r == HAVE) && stall_i;

  fetch_perf_ctr u_fetched_ctr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (fetched_en_s),
    .count_o (perf_fetched_o)
  );

  fetch_perf_ctr u_stall_ctr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (stall_en_s),
    .count_o (perf_stall_o)
  );
`endif

  fetch_unit_chk u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_rvalid_i (imem_rvalid_i),
    .state_i       (state_r)
  );

endmodule
